// File: rtl/parity_arb_pkg.sv
// Shared types and constants for the two-port parity arbiter.
// Holds the FSM state enum, requester index type and port count.
package parity_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef logic req_idx_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with an owned priority pointer.
// Ports: clk, reset_n, req[1:0], en in; one-hot gnt[1:0] out.
import parity_arb_pkg::*;

module rr_arb2 (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    req_idx_t           r_ptr;
    logic [NUM_REQ-1:0] w_gnt;

    always_comb begin
        w_gnt = '0;
        if (en) begin
            unique case (req)
                2'b11:   w_gnt[r_ptr] = 1'b1;
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                default: w_gnt = '0;
            endcase
        end
    end

    // After a grant the pointer moves to the other requester:
    // grant 0 -> ptr 1, grant 1 -> ptr 0, i.e. ptr = gnt[0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (|w_gnt) begin
            r_ptr <= w_gnt[0];
        end
    end

    assign gnt = w_gnt;

endmodule

// File: rtl/parity_arb_2port.sv
// Two requesters share one registered response slot; each byte
// gets a parity bit. Ports: reqN_val/msg in, reqN_rdy out;
// odd_mode in; resp_val/src/data/parity out, resp_rdy in;
// par_cnt out counts delivered parity-1 responses (saturating).
import parity_arb_pkg::*;

module parity_arb_2port #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [7:0]       req0_msg,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [7:0]       req1_msg,
    input  logic             odd_mode,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_src,
    output logic [7:0]       resp_data,
    output logic             resp_parity,
    output logic [CNT_W-1:0] par_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    req_idx_t           r_src;
    logic [7:0]         r_data;
    logic               r_parity;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_resp_xfer;
    logic               w_can_accept;
    logic               w_acc;
    req_idx_t           w_src;
    logic [7:0]         w_msg;
    logic               w_parity;

    assign w_resp_xfer = (r_state == FULL) & resp_rdy;

    // Gating with reset_n keeps both ready lines low while
    // reset is held, even though the FSM then reads EMPTY.
    assign w_can_accept = reset_n &
                          ((r_state == EMPTY) | w_resp_xfer);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req1_val, req0_val}),
        .en      (w_can_accept),
        .gnt     (w_gnt)
    );

    assign w_acc    = |w_gnt;
    assign w_src    = w_gnt[1];
    assign w_msg    = w_gnt[1] ? req1_msg : req0_msg;
    assign w_parity = (^w_msg) ^ odd_mode;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: begin
                if (w_acc) w_state_nxt = FULL;
            end
            FULL: begin
                if (w_resp_xfer && !w_acc) w_state_nxt = EMPTY;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src    <= 1'b0;
            r_data   <= 8'h00;
            r_parity <= 1'b0;
        end else if (w_acc) begin
            r_src    <= w_src;
            r_data   <= w_msg;
            r_parity <= w_parity;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_resp_xfer && r_parity && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign req0_rdy    = w_gnt[0];
    assign req1_rdy    = w_gnt[1];
    assign resp_val    = (r_state == FULL);
    assign resp_src    = r_src;
    assign resp_data   = r_data;
    assign resp_parity = r_parity;
    assign par_cnt     = r_cnt;

endmodule
